multiport_ram_2r2w: RTL and testbench
=====================================

# multiport_ram_2r2w

Two-read, two-write synchronous RAM, parameterised in depth and width, on a single clock. It backs the predictor's value and confidence tables: read ports A/B serve the forward (prediction) lanes and write ports A/B serve the feedback (update) lanes. All four ports operate every cycle, with registered (1-cycle) reads and write-port-B priority on address collisions.

## Interface
Parameters:
- P_MEM_DEPTH, 2048: number of entries; need not be a power of two.
- P_MEM_WIDTH, 32: bits per entry.
- P_ADDR_WIDTH (localparam), $clog2(P_MEM_DEPTH): address width.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rda_addr_i  in  P_ADDR_WIDTH  read port A address; always enabled.
- rdb_addr_i  in  P_ADDR_WIDTH  read port B address; always enabled.
- rda_data_o  out  P_MEM_WIDTH  read port A data, registered.
- rdb_data_o  out  P_MEM_WIDTH  read port B data, registered.
- wra_addr_i  in  P_ADDR_WIDTH  write port A address.
- wra_data_i  in  P_MEM_WIDTH  write port A data.
- wra_valid_i  in  1  write port A enable.
- wrb_addr_i  in  P_ADDR_WIDTH  write port B address.
- wrb_data_i  in  P_MEM_WIDTH  write port B data.
- wrb_valid_i  in  1  write port B enable.

## Operation
- Storage is a flop array of P_MEM_DEPTH x P_MEM_WIDTH.
- Reset: while rst_i=1 at a clock edge, the following happens:
  - Every entry is cleared to 0.
  - rda_data_o and rdb_data_o are set to 0.
  - Both write enables are ignored.
- Reset clears all entries on the same edge, regardless of any operation in flight.
- Write, per port: at the edge, mem[addr] <= data when valid=1, rst_i=0 and addr < P_MEM_DEPTH.
- Write collision: if both ports are valid and wra_addr_i == wrb_addr_i, port B's data is stored. Port A's write is dropped.
- Writes to different addresses in the same cycle both complete.
- Read, per port: at each edge, data_o <= mem[addr], using the array contents before that edge's writes (read-old-data).
  - Addresses >= P_MEM_DEPTH read as 0.
- Both read ports may use the same address and return identical data.
- Reads are not gated by any enable. The outputs update every non-reset cycle.
- No X propagation: every entry is defined from the first reset onward.

## Timing
- Read latency is 1 cycle. An address presented in cycle N appears on data_o in cycle N+1 and holds until the next edge.
- Write latency is 1 cycle. Data written at edge N is readable by an address presented in cycle N+1, with data out in cycle N+2.
- Same-cycle read and write to one address: the read returns the old value. The new value is visible from the next read.
- Output reset value is 0 on both read ports during the cycle after a reset edge.
- The first post-reset reads of any address return 0.
- Deasserting reset mid-stream requires no recovery: ports are fully functional on the first edge with rst_i=0.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to address 5, then pulse rst_i for 1 cycle, then read address 5 on ports A and B.
  - Required: both ports output 0, and both outputs are 0 in the cycle right after the reset edge.
- Dual independent write and read:
  - Stimulus: write A: addr 3 = 0x11111111 and write B: addr 7 = 0x22222222 in the same cycle; next cycle read A=7, B=3.
  - Required: one cycle later rda_data_o=0x22222222 and rdb_data_o=0x11111111.
- Write collision:
  - Stimulus: both ports valid at addr 9, with A data 0xAAAA0000 and B data 0x0000BBBB.
  - Required: a subsequent read of addr 9 returns 0x0000BBBB.
- Read-during-write:
  - Stimulus: addr 2 holds 0x5; in one cycle write 0x6 to addr 2 via port A while reading addr 2 on both ports.
  - Required: the outputs show 0x5; next cycle, reading addr 2 shows 0x6.
- Disabled write and write under reset:
  - Stimulus: drive wra_data_i=0xFF to addr 4 with wra_valid_i=0; then drive wrb_valid_i=1 with 0xFF to addr 4 while rst_i=1.
  - Required: addr 4 reads 0 in both cases.
- Width and depth:
  - Stimulus: with P_MEM_DEPTH=2048 and P_MEM_WIDTH=8, write 0x80 to addr 2047 via port B, then read it back on port A.
  - Required: port A returns 0x80.

Source files
------------

// File: rtl/multiport_ram_2r2w.sv
// -----------------------------------------------------------------------------
// multiport_ram_2r2w
// Two-read / two-write flop-array RAM on a single clock.
// - Read ports A/B are always enabled and registered (1-cycle latency).
//   They return the array contents from before the same edge's writes.
// - Write ports A/B commit on the rising edge.
//   On an address collision, port B's data wins and port A's write is dropped.
// - Addresses at or beyond P_MEM_DEPTH are ignored on write and read as zero.
//   This lets the depth be a non-power-of-two.
// - A synchronous active-high reset clears every entry and both read outputs.
//   Writes are suppressed on that edge, so no entry is ever undefined.
// -----------------------------------------------------------------------------
module multiport_ram_2r2w #(
    parameter int   P_MEM_DEPTH  = 2048,
    parameter int   P_MEM_WIDTH  = 32,
    localparam int  P_ADDR_WIDTH = $clog2(P_MEM_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [P_ADDR_WIDTH-1:0] rda_addr_i,
    input  logic [P_ADDR_WIDTH-1:0] rdb_addr_i,
    output logic [P_MEM_WIDTH-1:0]  rda_data_o,
    output logic [P_MEM_WIDTH-1:0]  rdb_data_o,
    input  logic [P_ADDR_WIDTH-1:0] wra_addr_i,
    input  logic [P_MEM_WIDTH-1:0]  wra_data_i,
    input  logic                    wra_valid_i,
    input  logic [P_ADDR_WIDTH-1:0] wrb_addr_i,
    input  logic [P_MEM_WIDTH-1:0]  wrb_data_i,
    input  logic                    wrb_valid_i
);

    // The depth is held one bit wider than an address.
    // This keeps the range comparison exact when the depth is a power of two.
    localparam logic [P_ADDR_WIDTH:0] L_DEPTH = (P_ADDR_WIDTH + 1)'(P_MEM_DEPTH);

    // Storage and registered read outputs
    logic [P_MEM_WIDTH-1:0] mem_q [P_MEM_DEPTH];
    logic [P_MEM_WIDTH-1:0] rda_data_q;
    logic [P_MEM_WIDTH-1:0] rdb_data_q;
    logic [P_MEM_WIDTH-1:0] rda_data_d;
    logic [P_MEM_WIDTH-1:0] rdb_data_d;

    // Address decode and qualified write enables
    logic rda_in_range_s;
    logic rdb_in_range_s;
    logic wra_in_range_s;
    logic wrb_in_range_s;
    logic wra_en_s;
    logic wrb_en_s;
    logic wr_collide_s;

    // Range checks: flag every port address that falls inside the array.
    always_comb begin
        rda_in_range_s = ({1'b0, rda_addr_i} < L_DEPTH);
        rdb_in_range_s = ({1'b0, rdb_addr_i} < L_DEPTH);
        wra_in_range_s = ({1'b0, wra_addr_i} < L_DEPTH);
        wrb_in_range_s = ({1'b0, wrb_addr_i} < L_DEPTH);
    end

    // Write qualification: port B owns a shared address, so port A yields to it.
    always_comb begin
        wrb_en_s     = wrb_valid_i && wrb_in_range_s;
        wr_collide_s = wrb_en_s && (wra_addr_i == wrb_addr_i);
        wra_en_s     = wra_valid_i && wra_in_range_s && !wr_collide_s;
    end

    // Read port A next value: old array contents, zero when out of range.
    always_comb begin
        rda_data_d = {P_MEM_WIDTH{1'b0}};
        if (rda_in_range_s) begin
            rda_data_d = mem_q[rda_addr_i];
        end else begin
            rda_data_d = {P_MEM_WIDTH{1'b0}};
        end
    end

    // Read port B next value: old array contents, zero when out of range.
    always_comb begin
        rdb_data_d = {P_MEM_WIDTH{1'b0}};
        if (rdb_in_range_s) begin
            rdb_data_d = mem_q[rdb_addr_i];
        end else begin
            rdb_data_d = {P_MEM_WIDTH{1'b0}};
        end
    end

    // Array update: clear everything on reset, otherwise commit qualified writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < P_MEM_DEPTH; i++) begin
                mem_q[i] <= {P_MEM_WIDTH{1'b0}};
            end
        end else begin
            if (wra_en_s) begin
                mem_q[wra_addr_i] <= wra_data_i;
            end
            if (wrb_en_s) begin
                mem_q[wrb_addr_i] <= wrb_data_i;
            end
        end
    end

    // Read output registers: zero on reset, otherwise capture every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rda_data_q <= {P_MEM_WIDTH{1'b0}};
            rdb_data_q <= {P_MEM_WIDTH{1'b0}};
        end else begin
            rda_data_q <= rda_data_d;
            rdb_data_q <= rdb_data_d;
        end
    end

    assign rda_data_o = rda_data_q;
    assign rdb_data_o = rdb_data_q;

endmodule

// File: tb/tb_multiport_ram_2r2w.sv
// -----------------------------------------------------------------------------
// Testbench for multiport_ram_2r2w.
// Two instances share one stimulus stream:
// - u_dut32: depth 2000, 32 bits. Addresses 2000..2047 are out of range.
// - u_dut8:  depth 2048, 8 bits. It receives the low byte of each data word.
// A behavioural array model predicts both read outputs every cycle.
// -----------------------------------------------------------------------------
module tb_multiport_ram_2r2w;

    localparam int D32 = 2000;
    localparam int D8  = 2048;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra, rb, wa, wb;
    logic [31:0]   wda, wdb;
    logic          wav, wbv;
    logic [31:0]   rda32, rdb32;
    logic [7:0]    rda8, rdb8;

    // Reference model state
    logic [31:0] m32 [D32];
    logic [7:0]  m8  [D8];
    logic [31:0] e_a32, e_b32;
    logic [7:0]  e_a8, e_b8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multiport_ram_2r2w #(.P_MEM_DEPTH(D32), .P_MEM_WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .rda_addr_i(ra), .rdb_addr_i(rb),
        .rda_data_o(rda32), .rdb_data_o(rdb32),
        .wra_addr_i(wa), .wra_data_i(wda), .wra_valid_i(wav),
        .wrb_addr_i(wb), .wrb_data_i(wdb), .wrb_valid_i(wbv)
    );

    multiport_ram_2r2w #(.P_MEM_DEPTH(D8), .P_MEM_WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst),
        .rda_addr_i(ra), .rdb_addr_i(rb),
        .rda_data_o(rda8), .rdb_data_o(rdb8),
        .wra_addr_i(wa), .wra_data_i(wda[7:0]), .wra_valid_i(wav),
        .wrb_addr_i(wb), .wrb_data_i(wdb[7:0]), .wrb_valid_i(wbv)
    );

    task automatic drive(input logic r, input logic [AW-1:0] a_rd, input logic [AW-1:0] b_rd,
                         input logic av, input logic [AW-1:0] a_wr, input logic [31:0] a_d,
                         input logic bv, input logic [AW-1:0] b_wr, input logic [31:0] b_d);
        rst = r; ra = a_rd; rb = b_rd;
        wav = av; wa = a_wr; wda = a_d;
        wbv = bv; wb = b_wr; wdb = b_d;
    endtask

    // One clock edge: the model reads old contents, then applies writes.
    // Port B is applied last so that it wins a collision.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            e_a32 = 32'h0; e_b32 = 32'h0; e_a8 = 8'h0; e_b8 = 8'h0;
            for (int i = 0; i < D32; i++) m32[i] = 32'h0;
            for (int i = 0; i < D8; i++)  m8[i]  = 8'h0;
        end else begin
            e_a32 = (int'(ra) < D32) ? m32[ra] : 32'h0;
            e_b32 = (int'(rb) < D32) ? m32[rb] : 32'h0;
            e_a8  = (int'(ra) < D8)  ? m8[ra]  : 8'h0;
            e_b8  = (int'(rb) < D8)  ? m8[rb]  : 8'h0;
            if (wav && int'(wa) < D32) m32[wa] = wda;
            if (wbv && int'(wb) < D32) m32[wb] = wdb;
            if (wav && int'(wa) < D8)  m8[wa]  = wda[7:0];
            if (wbv && int'(wb) < D8)  m8[wb]  = wdb[7:0];
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 11'd0, 11'd0, 1'b1, 11'd5, 32'hDEADBEEF, 1'b0, 11'd0, 32'h0);
        tick();
        drive(1'b1, 11'd5, 11'd5, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h0) begin n_fail++; $display("FAIL reset_cycle_a got=%h exp=%h", rda32, 32'h0); end
        n_cmp++; if (rdb32 !== 32'h0) begin n_fail++; $display("FAIL reset_cycle_b got=%h exp=%h", rdb32, 32'h0); end
        drive(1'b0, 11'd5, 11'd5, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h0) begin n_fail++; $display("FAIL reset_clear_a got=%h exp=%h", rda32, 32'h0); end
        n_cmp++; if (rdb32 !== 32'h0) begin n_fail++; $display("FAIL reset_clear_b got=%h exp=%h", rdb32, 32'h0); end
        n_cmp++; if (rda8 !== 8'h0) begin n_fail++; $display("FAIL reset_clear_a8 got=%h exp=%h", rda8, 8'h0); end
    endtask

    task automatic test_dual_write();
        drive(1'b0, 11'd0, 11'd0, 1'b1, 11'd3, 32'h11111111, 1'b1, 11'd7, 32'h22222222);
        tick();
        drive(1'b0, 11'd7, 11'd3, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h22222222) begin n_fail++; $display("FAIL dual_a got=%h exp=%h", rda32, 32'h22222222); end
        n_cmp++; if (rdb32 !== 32'h11111111) begin n_fail++; $display("FAIL dual_b got=%h exp=%h", rdb32, 32'h11111111); end
        n_cmp++; if (rda8 !== 8'h22) begin n_fail++; $display("FAIL dual_a8 got=%h exp=%h", rda8, 8'h22); end
        n_cmp++; if (rdb8 !== 8'h11) begin n_fail++; $display("FAIL dual_b8 got=%h exp=%h", rdb8, 8'h11); end
    endtask

    task automatic test_collision();
        drive(1'b0, 11'd0, 11'd0, 1'b1, 11'd9, 32'hAAAA0000, 1'b1, 11'd9, 32'h0000BBBB);
        tick();
        drive(1'b0, 11'd9, 11'd9, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h0000BBBB) begin n_fail++; $display("FAIL collide_a got=%h exp=%h", rda32, 32'h0000BBBB); end
        n_cmp++; if (rdb32 !== 32'h0000BBBB) begin n_fail++; $display("FAIL collide_b got=%h exp=%h", rdb32, 32'h0000BBBB); end
        n_cmp++; if (rdb8 !== 8'hBB) begin n_fail++; $display("FAIL collide_b8 got=%h exp=%h", rdb8, 8'hBB); end
    endtask

    task automatic test_read_during_write();
        drive(1'b0, 11'd0, 11'd0, 1'b0, 11'd0, 32'h0, 1'b1, 11'd2, 32'h5);
        tick();
        drive(1'b0, 11'd2, 11'd2, 1'b1, 11'd2, 32'h6, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h5) begin n_fail++; $display("FAIL rdw_old_a got=%h exp=%h", rda32, 32'h5); end
        n_cmp++; if (rdb32 !== 32'h5) begin n_fail++; $display("FAIL rdw_old_b got=%h exp=%h", rdb32, 32'h5); end
        drive(1'b0, 11'd2, 11'd2, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h6) begin n_fail++; $display("FAIL rdw_new_a got=%h exp=%h", rda32, 32'h6); end
        n_cmp++; if (rdb32 !== 32'h6) begin n_fail++; $display("FAIL rdw_new_b got=%h exp=%h", rdb32, 32'h6); end
    endtask

    task automatic test_disabled_write();
        drive(1'b0, 11'd4, 11'd4, 1'b0, 11'd4, 32'hFF, 1'b0, 11'd0, 32'h0);
        tick();
        drive(1'b0, 11'd4, 11'd4, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h0) begin n_fail++; $display("FAIL nowrite_a got=%h exp=%h", rda32, 32'h0); end
        n_cmp++; if (rdb8 !== 8'h0) begin n_fail++; $display("FAIL nowrite_b8 got=%h exp=%h", rdb8, 8'h0); end
        drive(1'b1, 11'd4, 11'd4, 1'b0, 11'd0, 32'h0, 1'b1, 11'd4, 32'hFF);
        tick();
        drive(1'b0, 11'd4, 11'd4, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda32 !== 32'h0) begin n_fail++; $display("FAIL rstwrite_a got=%h exp=%h", rda32, 32'h0); end
        n_cmp++; if (rdb32 !== 32'h0) begin n_fail++; $display("FAIL rstwrite_b got=%h exp=%h", rdb32, 32'h0); end
    endtask

    task automatic test_width_depth();
        // 2047 is the top of the 8-bit array but beyond the 2000-entry array.
        drive(1'b0, 11'd0, 11'd0, 1'b1, 11'd1999, 32'h13579BDF, 1'b1, 11'd2047, 32'h00000080);
        tick();
        drive(1'b0, 11'd2047, 11'd1999, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        n_cmp++; if (rda8 !== 8'h80) begin n_fail++; $display("FAIL depth_top8 got=%h exp=%h", rda8, 8'h80); end
        n_cmp++; if (rda32 !== 32'h0) begin n_fail++; $display("FAIL depth_oor32 got=%h exp=%h", rda32, 32'h0); end
        n_cmp++; if (rdb32 !== 32'h13579BDF) begin n_fail++; $display("FAIL depth_last32 got=%h exp=%h", rdb32, 32'h13579BDF); end
        n_cmp++; if (rdb8 !== 8'hDF) begin n_fail++; $display("FAIL depth_last8 got=%h exp=%h", rdb8, 8'hDF); end
    endtask

    task automatic test_random();
        logic [AW-1:0] adr [4];
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 0) adr[k] = AW'($urandom_range(0, 15));
                else                           adr[k] = AW'($urandom_range(1990, 2047));
            end
            drive(($urandom_range(0, 63) == 0), adr[0], adr[1],
                  1'($urandom_range(0, 1)), adr[2], $urandom(),
                  1'($urandom_range(0, 1)), adr[3], $urandom());
            tick();
            n_cmp++; if (rda32 !== e_a32) begin n_fail++; $display("FAIL rand_a32 cyc=%0d got=%h exp=%h", n, rda32, e_a32); end
            n_cmp++; if (rdb32 !== e_b32) begin n_fail++; $display("FAIL rand_b32 cyc=%0d got=%h exp=%h", n, rdb32, e_b32); end
            n_cmp++; if (rda8 !== e_a8) begin n_fail++; $display("FAIL rand_a8 cyc=%0d got=%h exp=%h", n, rda8, e_a8); end
            n_cmp++; if (rdb8 !== e_b8) begin n_fail++; $display("FAIL rand_b8 cyc=%0d got=%h exp=%h", n, rdb8, e_b8); end
        end
    endtask

    initial begin
        drive(1'b1, 11'd0, 11'd0, 1'b0, 11'd0, 32'h0, 1'b0, 11'd0, 32'h0);
        tick();
        tick();
        test_reset();
        test_dual_write();
        test_collision();
        test_read_during_write();
        test_disabled_write();
        test_width_depth();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
